rst_seq_ctrl: RTL and testbench
===============================

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2: cycles core_rst stays asserted after synchronized reset release; legal range 1..255.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100004: run-cycle limit before the watchdog fires.
REQ-003 SHALL have parameter CNT_W, default 32: width of cycle_count.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port err, input, 1 bit: core error indication, sampled at rising edge.
REQ-007 SHALL have port halt, input, 1 bit: core normal-completion indication, sampled at rising edge.
REQ-008 SHALL have port core_rst, output, 1 bit: active-high reset to the processor core.
REQ-009 SHALL have port running, output, 1 bit: high only in RUN.
REQ-010 SHALL have port stop, output, 1 bit: high in any terminal state.
REQ-011 SHALL have port status, output, 2 bits: 00 none, 01 halted, 10 error, 11 timeout.
REQ-012 SHALL have port cycle_count, output, CNT_W bits: number of RUN cycles elapsed.

Function
REQ-013 SHALL implement states RESET, HOLD, RUN, DONE, ERROR, TIMEOUT, all outputs registered.
REQ-014 SHALL pass rst_n deassertion through a 2-flop synchronizer; RESET -> HOLD on the first edge where the synchronized release is seen.
REQ-015 SHALL keep core_rst=1 in RESET and HOLD; HOLD lasts exactly HOLD_CYCLES clocks, then -> RUN with core_rst=0.
REQ-016 SHALL increment cycle_count by 1 on every edge in RUN, saturating at all-ones with no wrap.
REQ-017 SHALL, in RUN, exit to ERROR on err=1, to DONE on halt=1, and to TIMEOUT when cycle_count reaches TIMEOUT_CYCLES.
REQ-018 SHALL resolve simultaneous exit conditions with priority err > halt > timeout.
REQ-019 SHALL ignore err and halt in RESET, HOLD and terminal states.
REQ-020 SHALL hold DONE, ERROR and TIMEOUT until rst_n is asserted: stop=1, running=0, core_rst=0, cycle_count frozen.
REQ-021 SHALL update status in the same edge that enters the terminal state; status stays 00 in non-terminal states.
REQ-022 SHALL make every output change visible one clock after the sampled condition, i.e. latency 1.

Reset
REQ-023 SHALL, on rst_n=0 at any time including mid-HOLD or mid-RUN, immediately and asynchronously force state=RESET, core_rst=1, running=0, stop=0, status=00, cycle_count=0, and clear both synchronizer flops.
REQ-024 SHALL deassert internal reset only through the synchronizer; core_rst falls no earlier than 2+HOLD_CYCLES edges after rst_n rises.

Configuration
REQ-025 SHALL compile the watchdog in when macro RST_SEQ_WATCHDOG_EN is defined: TIMEOUT state reachable per REQ-017.
REQ-026 SHALL, when RST_SEQ_WATCHDOG_EN is undefined, omit the timeout compare: TIMEOUT unreachable, status never 11, cycle_count still counts and saturates.

Verification
REQ-027 SHALL cover reset release: HOLD_CYCLES=2; rst_n rises -> core_rst falls on the 4th rising edge after release, running=1, cycle_count=0 in the first RUN cycle.
REQ-028 SHALL cover normal completion: halt=1 after 10 RUN cycles -> status=01, stop=1, cycle_count frozen at 10.
REQ-029 SHALL cover priority: err=1 and halt=1 in the same cycle -> status=10.
REQ-030 SHALL cover watchdog: TIMEOUT_CYCLES=20 with macro defined, no err/halt -> status=11 once cycle_count=20; with macro undefined -> still RUN at cycle 40.
REQ-031 SHALL cover mid-run reset: rst_n=0 pulse in RUN at cycle 7 -> outputs return to reset values with no clock edge, then the full HOLD sequence repeats.
REQ-032 SHALL cover ignored inputs: err=1 during HOLD -> still reaches RUN, status=00.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds the core in reset after a synchronized release, runs it, and latches how the run ended.
// Define RST_SEQ_WATCHDOG_EN to compile in the run-cycle watchdog (TIMEOUT state).
module rst_seq_ctrl #(
    parameter int HOLD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 100004,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             err,
    input  logic             halt,
    output logic             core_rst,
    output logic             running,
    output logic             stop,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [2:0] S_RESET   = 3'd0;
    localparam logic [2:0] S_HOLD    = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_ERROR   = 3'd4;
    localparam logic [2:0] S_TIMEOUT = 3'd5;

`ifdef RST_SEQ_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;
`endif

    logic             sync1, sync2;
    logic [2:0]       state, state_n;
    logic [7:0]       hold_cnt, hold_n;
    logic [CNT_W-1:0] cnt_n, cnt_inc;
    logic [1:0]       status_n;

    assign cnt_inc = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;

    // RESET leaves on the edge where the second synchronizer flop captures the release.
    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        cnt_n   = cycle_count;
        case (state)
            S_RESET: begin
                if (sync1) begin
                    state_n = S_HOLD;
                    hold_n  = 8'd0;
                end
            end
            S_HOLD: begin
                if (sync2) begin
                    if (hold_cnt == 8'(HOLD_CYCLES - 1)) state_n = S_RUN;
                    else                                 hold_n  = hold_cnt + 8'd1;
                end
            end
            S_RUN: begin
                if (err)       state_n = S_ERROR;
                else if (halt) state_n = S_DONE;
                else begin
                    cnt_n = cnt_inc;
`ifdef RST_SEQ_WATCHDOG_EN
                    if (cnt_inc == TMO) state_n = S_TIMEOUT;
`endif
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        status_n = 2'b00;
        case (state_n)
            S_DONE:    status_n = 2'b01;
            S_ERROR:   status_n = 2'b10;
            S_TIMEOUT: status_n = 2'b11;
            default:   status_n = 2'b00;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            state       <= S_RESET;
            hold_cnt    <= 8'd0;
            core_rst    <= 1'b1;
            running     <= 1'b0;
            stop        <= 1'b0;
            status      <= 2'b00;
            cycle_count <= '0;
        end else begin
            sync1       <= 1'b1;
            sync2       <= sync1;
            state       <= state_n;
            hold_cnt    <= hold_n;
            core_rst    <= (state_n == S_RESET) || (state_n == S_HOLD);
            running     <= (state_n == S_RUN);
            stop        <= (state_n == S_DONE) || (state_n == S_ERROR) || (state_n == S_TIMEOUT);
            status      <= status_n;
            cycle_count <= cnt_n;
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: stimulus queues expected outputs, a monitor pops and compares.
module tb_rst_seq_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n, err, halt;
    logic             core_rst, running, stop;
    logic [1:0]       status;
    logic [CNT_W-1:0] cycle_count;

    typedef struct {
        string       name;
        logic        cr;
        logic        rn;
        logic        sp;
        logic [1:0]  st;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    event chk_ev;

    rst_seq_ctrl #(.HOLD_CYCLES(2), .TIMEOUT_CYCLES(20), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .err(err), .halt(halt),
        .core_rst(core_rst), .running(running), .stop(stop),
        .status(status), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic push(input string n, input bit cr, input bit rn, input bit sp,
                        input bit [1:0] st, input int c);
        exp_t e;
        e.name = n; e.cr = cr; e.rn = rn; e.sp = sp; e.st = st; e.cnt = c;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are compared on the falling edge, or immediately when an
    // asynchronous check is requested.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (core_rst !== e.cr || running !== e.rn || stop !== e.sp ||
                    status !== e.st || cycle_count !== e.cnt) begin
                    bad++;
                    $display("FAIL %s: got cr=%b rn=%b sp=%b st=%b cnt=%0d, want cr=%b rn=%b sp=%b st=%b cnt=%0d",
                             e.name, core_rst, running, stop, status, cycle_count,
                             e.cr, e.rn, e.sp, e.st, e.cnt);
                end
            end
        end
    end

    // Assert reset asynchronously, release it, and walk through the HOLD sequence into RUN.
    task automatic bring_up(input bit err_hold);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        push("async_rst", 1, 0, 0, 2'b00, 0);
        -> chk_ev;
        step(); push("rst_a", 1, 0, 0, 2'b00, 0);
        step(); push("rst_b", 1, 0, 0, 2'b00, 0);
        rst_n = 1'b1;
        if (err_hold) err = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step(); push($sformatf("hold_e%0d", i), 1, 0, 0, 2'b00, 0);
        end
        step(); push("run_first", 0, 1, 0, 2'b00, 0);
        err = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; err = 1'b0; halt = 1'b0;
        #2;
        step(); step();
        push("reset_state", 1, 0, 0, 2'b00, 0);

        // Release with err held through HOLD, then normal completion at count 10.
        bring_up(1'b1);
        for (int k = 1; k <= 10; k++) begin
            step(); push($sformatf("run_c%0d", k), 0, 1, 0, 2'b00, k);
        end
        halt = 1'b1;
        step(); push("done", 0, 0, 1, 2'b01, 10);
        halt = 1'b0; err = 1'b1;
        step(); push("done_hold_err", 0, 0, 1, 2'b01, 10);
        err = 1'b0; halt = 1'b1;
        step(); push("done_hold_halt", 0, 0, 1, 2'b01, 10);
        halt = 1'b0;

        // err and halt together: err wins.
        bring_up(1'b0);
        for (int k = 1; k <= 3; k++) begin
            step(); push($sformatf("prio_c%0d", k), 0, 1, 0, 2'b00, k);
        end
        err = 1'b1; halt = 1'b1;
        step(); push("prio_err", 0, 0, 1, 2'b10, 3);
        err = 1'b0; halt = 1'b0;
        step(); push("error_hold", 0, 0, 1, 2'b10, 3);

        // Mid-run reset at cycle 7, then a full sequence again.
        bring_up(1'b0);
        for (int k = 1; k <= 7; k++) begin
            step(); push($sformatf("mid_c%0d", k), 0, 1, 0, 2'b00, k);
        end
        bring_up(1'b0);
        step(); push("rerun_c1", 0, 1, 0, 2'b00, 1);

        // Watchdog: TIMEOUT_CYCLES=20.
        bring_up(1'b0);
        for (int k = 1; k <= 40; k++) begin
            step();
`ifdef RST_SEQ_WATCHDOG_EN
            if (k < 20) push($sformatf("wd_c%0d", k), 0, 1, 0, 2'b00, k);
            else        push($sformatf("wd_tmo%0d", k), 0, 0, 1, 2'b11, 20);
`else
            push($sformatf("wd_c%0d", k), 0, 1, 0, 2'b00, k);
`endif
        end

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
